// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the shared-FIFO write arbiter: FSM encoding,
// default burst length and ID width derivation.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  localparam int DEF_MAX_BURST = 16;

  // Minimum source-ID width able to name every requester (at least 1 bit).
  function automatic int id_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side handshake plus FIFO write-port signals of the arbiter.
// master = environment (requesters + FIFO), slave = arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 16,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;

  logic                  fifo_wen;
  logic [DW+ID_W-1:0]    fifo_wdata;
  logic                  fifo_wclr;
  logic                  fifo_wfull;
  logic                  fifo_prog_full;
  logic                  fifo_overflow;

  modport master (
    output req_valid, req_last, req_data,
    output fifo_wfull, fifo_prog_full, fifo_overflow,
    input  req_ready, fifo_wen, fifo_wdata, fifo_wclr
  );

  modport slave (
    input  req_valid, req_last, req_data,
    input  fifo_wfull, fifo_prog_full, fifo_overflow,
    output req_ready, fifo_wen, fifo_wdata, fifo_wclr
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_arb_pick.sv
// Combinational round-robin pick: first requesting index after last_grant,
// wrapping modulo NUM_REQ.
module rr_arb_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);
  int   idx;
  logic found;

  always_comb begin
    winner  = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    // Scan from last_grant+1 so the previous winner is checked last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-based round-robin arbiter sharing one FIFO write port between
// NUM_REQ writers; each word is tagged with its source ID.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DW        = 16,
  parameter int ID_W      = id_width(NUM_REQ),
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int BC_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  fifo_wr_arbiter_if.slave     bus,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 ovf_err
);
  state_t             state, state_nx;
  logic [ID_W-1:0]    last_grant, winner;
  logic [BC_W-1:0]    burst_cnt;
  logic               any_req, start, xfer;
  logic               g_valid, g_last;
  logic [DW-1:0]      g_data;
  logic [NUM_REQ-1:0] ready;

  rr_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign g_valid = bus.req_valid[grant_id];
  assign g_last  = bus.req_last[grant_id];
  assign g_data  = bus.req_data[grant_id*DW +: DW];

  always_comb begin
    state_nx = state;
    ready    = '0;
    start    = 1'b0;
    xfer     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req && !bus.fifo_prog_full) begin
          start    = 1'b1;
          state_nx = ST_XFER;
        end
      end
      ST_XFER: begin
        // A word accepted in a clear/reset cycle would be dropped by the FIFO clear.
        ready[grant_id] = ~bus.fifo_wfull & ~rst & ~clr;
        xfer            = g_valid & ready[grant_id];
        if (!g_valid || (xfer && (g_last || burst_cnt == BC_W'(MAX_BURST - 1))))
          state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state      <= ST_IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
      ovf_err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) begin
        grant_id   <= winner;
        last_grant <= winner;
        burst_cnt  <= '0;
      end else if (xfer) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
      if (bus.fifo_overflow)
        ovf_err <= 1'b1;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.fifo_wen   = xfer;
  assign bus.fifo_wdata = {grant_id, g_data};
  assign bus.fifo_wclr  = clr;
  assign busy           = (state == ST_XFER);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: requesters send {id, word index}
// payloads; expected FIFO words are queued when stimulus is set up.
module tb_fifo_wr_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 16;
  localparam int IDW = 2;
  localparam int MB  = 16;

  logic           clk = 1'b0;
  logic           rst, clr;
  logic [IDW-1:0] grant_id;
  logic           busy, ovf_err;

  int total = 0;
  int bad   = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DW(DW), .ID_W(IDW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(NR), .DW(DW), .ID_W(IDW), .MAX_BURST(MB), .BC_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy),
    .ovf_err  (ovf_err)
  );

  always #5 clk = ~clk;

  // Requester models: send words until sent reaches goal.
  int   goal [NR];
  int   sent [NR];
  logic last_en [NR];

  always_comb begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]          = (sent[i] < goal[i]);
      bus.req_last[i]           = last_en[i] && (sent[i] == goal[i] - 1);
      bus.req_data[i*DW +: DW]  = {4'(i), 12'(sent[i])};
    end
  end

  always @(posedge clk)
    for (int i = 0; i < NR; i++)
      if (bus.req_valid[i] && bus.req_ready[i]) sent[i] <= sent[i] + 1;

  // Scoreboard monitor
  logic [DW+IDW-1:0] exp_q [$];
  logic [DW+IDW-1:0] mon_e;
  int                wr_cnt = 0;
  logic              prev_wen = 1'b0;
  logic [IDW-1:0]    prev_id = '0;
  bit                ovf_expect = 1'b0;

  always @(negedge clk) begin
    if (bus.fifo_wen) begin
      wr_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got %h, required no write", bus.fifo_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.fifo_wdata !== mon_e) begin
          bad++;
          $display("FAIL sb_data: got %h, required %h", bus.fifo_wdata, mon_e);
        end
      end
      if (prev_wen) begin
        total++;
        if (bus.fifo_wdata[DW +: IDW] !== prev_id) begin
          bad++;
          $display("FAIL idle_gap: id %0d followed id %0d with no idle cycle",
                   bus.fifo_wdata[DW +: IDW], prev_id);
        end
      end
    end
    prev_wen = bus.fifo_wen;
    prev_id  = bus.fifo_wdata[DW +: IDW];
    if (ovf_err && !ovf_expect) begin
      total++;
      bad++;
      $display("FAIL ovf_unexpected: got ovf_err=1, required 0");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int r, input int from, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back({2'(r), 4'(r), 12'(from + k)});
  endtask

  task automatic wait_writes(input int n, input string name);
    int t = 0;
    while (wr_cnt < n && t < 500) begin tick(); t++; end
    if (wr_cnt < n) begin
      total++; bad++;
      $display("FAIL %s_timeout: got %0d writes, required %0d", name, wr_cnt, n);
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 500) begin tick(); t++; end
    if (busy) begin
      total++; bad++;
      $display("FAIL %s_idle_timeout: got busy=1, required 0", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    goal[1] = sent[1] + 1;
    last_en[1] = 1'b1;
    repeat (3) tick();
    total += 5;
    if (busy !== 1'b0)          begin bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (grant_id !== 2'd0)      begin bad++; $display("FAIL rst_grant: got %0d, required 0", grant_id); end
    if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL rst_ready: got %b, required 0000", bus.req_ready); end
    if (bus.fifo_wen !== 1'b0)  begin bad++; $display("FAIL rst_wen: got %b, required 0", bus.fifo_wen); end
    if (ovf_err !== 1'b0)       begin bad++; $display("FAIL rst_ovf: got %b, required 0", ovf_err); end
    push_exp(1, sent[1], 1);
    rst = 1'b0;
    tick();
    total += 2;
    if (busy !== 1'b1)     begin bad++; $display("FAIL rst_first_busy: got %b, required 1", busy); end
    if (grant_id !== 2'd1) begin bad++; $display("FAIL rst_first_grant: got %0d, required 1", grant_id); end
    wait_idle("reset");
    tick();
    last_en[1] = 1'b0;
  endtask

  task automatic test_single();
    int b = wr_cnt;
    int bc = 0;
    push_exp(2, sent[2], 5);
    last_en[2] = 1'b1;
    goal[2] = sent[2] + 5;
    repeat (20) begin tick(); if (busy) bc++; end
    total += 3;
    if (wr_cnt - b !== 5)  begin bad++; $display("FAIL single_writes: got %0d, required 5", wr_cnt - b); end
    if (bc !== 5)          begin bad++; $display("FAIL single_busy: got %0d cycles, required 5", bc); end
    if (grant_id !== 2'd2) begin bad++; $display("FAIL single_grant: got %0d, required 2", grant_id); end
    last_en[2] = 1'b0;
  endtask

  task automatic test_round_robin();
    int b;
    int s[NR];
    clr = 1'b1;
    tick();
    clr = 1'b0;
    b = wr_cnt;
    for (int i = 0; i < NR; i++) s[i] = sent[i];
    push_exp(0, s[0], MB);
    for (int i = 1; i < NR; i++) push_exp(i, s[i], MB);
    push_exp(0, s[0] + MB, MB);
    for (int i = 1; i < NR; i++) push_exp(i, s[i] + MB, 1);
    goal[0] = s[0] + 2 * MB;
    for (int i = 1; i < NR; i++) goal[i] = s[i] + MB + 1;
    wait_writes(b + 5 * MB + 3, "rr");
    tick();
    wait_idle("rr");
    tick();
  endtask

  task automatic test_wfull_stall();
    int b = wr_cnt;
    push_exp(1, sent[1], 20);
    goal[1] = sent[1] + 20;
    wait_writes(b + 3, "wfull");
    bus.fifo_wfull = 1'b1;
    repeat (3) begin
      #1;
      total += 2;
      if (bus.req_ready[1] !== 1'b0) begin bad++; $display("FAIL wfull_ready: got %b, required 0", bus.req_ready[1]); end
      if (bus.fifo_wen !== 1'b0)     begin bad++; $display("FAIL wfull_wen: got %b, required 0", bus.fifo_wen); end
      tick();
    end
    total++;
    if (wr_cnt - b !== 3) begin bad++; $display("FAIL wfull_held: got %0d writes, required 3", wr_cnt - b); end
    bus.fifo_wfull = 1'b0;
    wait_idle("wfull");
    total++;
    if (wr_cnt - b !== MB) begin bad++; $display("FAIL wfull_burst_len: got %0d, required %0d", wr_cnt - b, MB); end
    wait_writes(b + 20, "wfull_tail");
    tick();
    wait_idle("wfull_tail");
    tick();
  endtask

  task automatic test_prog_full();
    int b = wr_cnt;
    bus.fifo_prog_full = 1'b1;
    push_exp(3, sent[3], 3);
    last_en[3] = 1'b1;
    goal[3] = sent[3] + 3;
    repeat (10) begin
      tick();
      total += 2;
      if (busy !== 1'b0)         begin bad++; $display("FAIL pf_hold_busy: got %b, required 0", busy); end
      if (bus.fifo_wen !== 1'b0) begin bad++; $display("FAIL pf_hold_wen: got %b, required 0", bus.fifo_wen); end
    end
    bus.fifo_prog_full = 1'b0;
    tick();
    total += 3;
    if (busy !== 1'b1)         begin bad++; $display("FAIL pf_grant_busy: got %b, required 1", busy); end
    if (grant_id !== 2'd3)     begin bad++; $display("FAIL pf_grant_id: got %0d, required 3", grant_id); end
    if (bus.fifo_wen !== 1'b1) begin bad++; $display("FAIL pf_first_wen: got %b, required 1", bus.fifo_wen); end
    // prog_full rising mid-burst must not cut it short
    bus.fifo_prog_full = 1'b1;
    tick();
    wait_idle("pf");
    total++;
    if (wr_cnt - b !== 3) begin bad++; $display("FAIL pf_midburst: got %0d writes, required 3", wr_cnt - b); end
    bus.fifo_prog_full = 1'b0;
    last_en[3] = 1'b0;
    tick();
  endtask

  task automatic test_clr();
    int b = wr_cnt;
    int s2 = sent[2];
    int s3 = sent[3];
    push_exp(2, s2, 2);
    last_en[2] = 1'b1;
    goal[2] = s2 + 8;
    wait_writes(b + 2, "clr");
    clr = 1'b1;
    push_exp(2, s2 + 2, 6);
    push_exp(3, s3, 1);
    last_en[3] = 1'b1;
    goal[3] = s3 + 1;
    #1;
    total += 3;
    if (bus.fifo_wclr !== 1'b1) begin bad++; $display("FAIL clr_wclr: got %b, required 1", bus.fifo_wclr); end
    if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL clr_ready: got %b, required 0000", bus.req_ready); end
    if (bus.fifo_wen !== 1'b0)  begin bad++; $display("FAIL clr_wen: got %b, required 0", bus.fifo_wen); end
    tick();
    clr = 1'b0;
    #1;
    total += 3;
    if (busy !== 1'b0)          begin bad++; $display("FAIL clr_idle: got busy=%b, required 0", busy); end
    if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL clr_idle_ready: got %b, required 0000", bus.req_ready); end
    if (bus.fifo_wclr !== 1'b0) begin bad++; $display("FAIL clr_wclr_drop: got %b, required 0", bus.fifo_wclr); end
    tick();
    total++;
    if (grant_id !== 2'd2) begin bad++; $display("FAIL clr_restart: got %0d, required 2", grant_id); end
    wait_writes(b + 9, "clr_tail");
    tick();
    wait_idle("clr_tail");
    last_en[2] = 1'b0;
    last_en[3] = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    ovf_expect = 1'b1;
    bus.fifo_overflow = 1'b1;
    tick();
    bus.fifo_overflow = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c % 25 == 0) begin
        total++;
        if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_hold: got %b at cycle %0d, required 1", ovf_err, c); end
      end
      tick();
    end
    total++;
    if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_hold_end: got %b, required 1", ovf_err); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b, required 0", ovf_err); end
    bus.fifo_overflow = 1'b1;
    tick();
    bus.fifo_overflow = 1'b0;
    total++;
    if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_set2: got %b, required 1", ovf_err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_rst: got %b, required 0", ovf_err); end
    tick();
    ovf_expect = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    bus.fifo_wfull     = 1'b0;
    bus.fifo_prog_full = 1'b0;
    bus.fifo_overflow  = 1'b0;
    for (int i = 0; i < NR; i++) begin
      goal[i]    = 0;
      last_en[i] = 1'b0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_wfull_stall();
    test_prog_full();
    test_clr();
    test_overflow();
    repeat (3) tick();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d pending words, required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
